// File: rtl/sia_rxq_ex.sv
// Serial receive queue: async (baud-timed) or sync (rxc-sampled) deframer feeding
// a small FIFO of raw frames tagged with a framing-error bit, plus overrun tracking.
module sia_rxq_ex #(
  parameter int SHIFT_REG_WIDTH = 12,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int DEPTH_BITS      = 2,
  parameter int OVR_CNT_BITS    = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [4:0]                 bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       sync_i,
  input  logic                       rxd_i,
  input  logic                       rxc_i,
  input  logic                       rxq_pop_i,
  input  logic                       rxq_oe_i,
  input  logic                       rxq_flush_i,
  input  logic [DEPTH_BITS:0]        hwm_i,
  input  logic                       err_clr_i,
  output logic [SHIFT_REG_WIDTH-1:0] rxq_dat_o,
  output logic                       rxq_ferr_o,
  output logic                       rxq_full_o,
  output logic                       rxq_not_empty_o,
  output logic [DEPTH_BITS:0]        rxq_level_o,
  output logic                       rxq_hwm_o,
  output logic                       rxq_ovr_o,
  output logic [OVR_CNT_BITS-1:0]    rxq_ovr_cnt_o
);
  localparam int SRW   = SHIFT_REG_WIDTH;
  localparam int BRW   = BAUD_RATE_WIDTH;
  localparam int DB    = DEPTH_BITS;
  localparam int DEPTH = 1 << DB;
  localparam logic [DB:0]    FULL_LVL = (DB+1)'(DEPTH);
  localparam logic [DB:0]    LVL_ONE  = (DB+1)'(1);
  localparam logic [DB-1:0]  PTR_ONE  = DB'(1);
  localparam logic [BRW-1:0] TMR_ONE  = BRW'(1);
  localparam logic [4:0]     SRW_BITS = 5'(SRW);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_PUSH} state_t;

  function automatic logic [OVR_CNT_BITS-1:0] sat_inc(input logic [OVR_CNT_BITS-1:0] v);
    return (&v) ? v : v + OVR_CNT_BITS'(1);
  endfunction

  logic rxd_m_q, rxd_s_q, rxd_p_q, rxc_m_q, rxc_s_q, rxc_p_q;
  logic rxd_fall, rxc_rise, sample_pt, push_req;
  logic [4:0] bits_eff;

  state_t           state_q, state_d;
  logic [BRW-1:0]   timer_q, timer_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [SRW-1:0]   sreg_q, sreg_d;
  logic             mode_q, mode_d;

  logic [SRW:0]     mem_q [DEPTH];
  logic [DB-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [DB:0]      level_q, level_d;
  logic [SRW:0]     head_q, head_d, push_word;
  logic             do_push, do_pop, drop, full;
  logic             ovr_q, ovr_d;
  logic [OVR_CNT_BITS-1:0] cnt_q, cnt_d;

  // Line idles high, so the rxd synchroniser resets to 1 to avoid a phantom start edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      {rxd_m_q, rxd_s_q, rxd_p_q} <= 3'b111;
      {rxc_m_q, rxc_s_q, rxc_p_q} <= 3'b000;
    end else begin
      rxd_m_q <= rxd_i;
      rxd_s_q <= rxd_m_q;
      rxd_p_q <= rxd_s_q;
      rxc_m_q <= rxc_i;
      rxc_s_q <= rxc_m_q;
      rxc_p_q <= rxc_s_q;
    end
  end

  assign rxd_fall  = rxd_p_q & ~rxd_s_q;
  assign rxc_rise  = rxc_s_q & ~rxc_p_q;
  assign bits_eff  = (bits_i > SRW_BITS) ? SRW_BITS : bits_i;
  assign sample_pt = mode_q ? rxc_rise : (timer_q == '0);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    mode_d   = mode_q;
    push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        mode_d = sync_i;
        if (bits_i >= 5'd2) begin
          if (!sync_i && rxd_fall) begin
            timer_d = baud_i >> 1;
            sreg_d  = '1;
            state_d = S_START;
          end else if (sync_i && rxc_rise && !rxd_s_q) begin
            sreg_d   = {1'b0, {(SRW-1){1'b1}}};
            bitcnt_d = bits_eff - 5'd1;
            state_d  = S_DATA;
          end
        end
      end
      S_START: begin
        if (timer_q == '0) begin
          if (rxd_s_q) begin
            state_d = S_IDLE;
          end else begin
            sreg_d   = {1'b0, sreg_q[SRW-1:1]};
            timer_d  = baud_i;
            bitcnt_d = bits_eff - 5'd1;
            state_d  = S_DATA;
          end
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_DATA: begin
        if (sample_pt) begin
          sreg_d   = {rxd_s_q, sreg_q[SRW-1:1]};
          timer_d  = baud_i;
          bitcnt_d = bitcnt_q - 5'd1;
          if (bitcnt_q == 5'd1) state_d = S_PUSH;
        end else if (!mode_q) begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_PUSH: begin
        push_req = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flush empties the queue but still accepts a push landing in the same cycle.
  always_comb begin
    push_word = {~sreg_q[SRW-1], sreg_q};
    full      = (level_q == FULL_LVL);
    do_pop    = rxq_pop_i && (level_q != '0) && !rxq_flush_i;
    do_push   = push_req && (!full || do_pop || rxq_flush_i);
    drop      = push_req && !do_push;
    wr_d      = do_push ? wr_q + PTR_ONE : wr_q;
    rd_d      = rxq_flush_i ? wr_q : (do_pop ? rd_q + PTR_ONE : rd_q);
    level_d   = level_q;
    if (rxq_flush_i)            level_d = do_push ? LVL_ONE : '0;
    else if (do_push && !do_pop) level_d = level_q + LVL_ONE;
    else if (do_pop && !do_push) level_d = level_q - LVL_ONE;
    head_d = head_q;
    if (level_d != '0) head_d = (do_push && rd_d == wr_q) ? push_word : mem_q[rd_d];
    ovr_d = ovr_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovr_d = 1'b1;
      cnt_d = err_clr_i ? OVR_CNT_BITS'(1) : sat_inc(cnt_q);
    end else if (err_clr_i) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      sreg_q   <= '1;
      mode_q   <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      head_q   <= '0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
      mode_q   <= mode_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      head_q   <= head_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_word;
  end

  assign rxq_dat_o       = rxq_oe_i ? head_q[SRW-1:0] : '0;
  assign rxq_ferr_o      = rxq_oe_i & head_q[SRW];
  assign rxq_full_o      = full;
  assign rxq_not_empty_o = (level_q != '0);
  assign rxq_level_o     = level_q;
  assign rxq_hwm_o       = (hwm_i != '0) && (level_q >= hwm_i);
  assign rxq_ovr_o       = ovr_q;
  assign rxq_ovr_cnt_o   = cnt_q;
endmodule

// File: tb/tb_sia_rxq_ex.sv
// Scoreboard bench for sia_rxq_ex: frames are modelled as whole words when sent,
// and a negedge monitor checks each word as it is popped from the queue.
`timescale 1ns/1ps
module tb_sia_rxq_ex;
  localparam int SRW = 12, DB = 2, DEPTH = 4, OCB = 2, CNT_MAX = 3;

  logic clk = 1'b0;
  logic reset_i, sync_i, rxd_i, rxc_i, rxq_pop_i, rxq_oe_i, rxq_flush_i, err_clr_i;
  logic [4:0] bits_i;
  logic [31:0] baud_i;
  logic [DB:0] hwm_i;
  logic [SRW-1:0] rxq_dat_o;
  logic rxq_ferr_o, rxq_full_o, rxq_not_empty_o, rxq_hwm_o, rxq_ovr_o;
  logic [DB:0] rxq_level_o;
  logic [OCB-1:0] rxq_ovr_cnt_o;

  sia_rxq_ex #(.SHIFT_REG_WIDTH(SRW), .BAUD_RATE_WIDTH(32), .DEPTH_BITS(DB), .OVR_CNT_BITS(OCB)) dut (
    .clk_i(clk), .reset_i(reset_i), .bits_i(bits_i), .baud_i(baud_i), .sync_i(sync_i),
    .rxd_i(rxd_i), .rxc_i(rxc_i), .rxq_pop_i(rxq_pop_i), .rxq_oe_i(rxq_oe_i),
    .rxq_flush_i(rxq_flush_i), .hwm_i(hwm_i), .err_clr_i(err_clr_i),
    .rxq_dat_o(rxq_dat_o), .rxq_ferr_o(rxq_ferr_o), .rxq_full_o(rxq_full_o),
    .rxq_not_empty_o(rxq_not_empty_o), .rxq_level_o(rxq_level_o), .rxq_hwm_o(rxq_hwm_o),
    .rxq_ovr_o(rxq_ovr_o), .rxq_ovr_cnt_o(rxq_ovr_cnt_o));

  always #10 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [SRW:0] exp_q[$];
  logic exp_ovr = 1'b0;
  int exp_cnt = 0;
  logic [SRW:0] last_w = '0;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Word popped while the queue is non-empty must match the model's oldest word.
  always @(negedge clk) begin
    if (rxq_pop_i && rxq_not_empty_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_extra: got %0h required no word", {rxq_ferr_o, rxq_dat_o});
      end else begin
        logic [SRW:0] w;
        w = exp_q.pop_front();
        if (rxq_oe_i) chk("pop_word", {rxq_ferr_o, rxq_dat_o}, w);
        else          chk("pop_word_oe0", {rxq_ferr_o, rxq_dat_o}, 0);
        last_w = w;
      end
    end
  end

  function automatic int frame_bits(input int nbits, input int data, input bit stop);
    return (int'(stop) << (nbits-1)) | ((data & ((1 << (nbits-2)) - 1)) << 1);
  endfunction

  // Frame bits occupy the top nbits of the register, untouched lower bits stay 1.
  function automatic logic [SRW:0] model_word(input int nbits, input int data, input bit stop);
    int low;
    logic [SRW-1:0] w;
    low = SRW - nbits;
    w = SRW'((frame_bits(nbits, data, stop) << low) | ((1 << low) - 1));
    return {~stop, w};
  endfunction

  task automatic model_push(input logic [SRW:0] w);
    if (exp_q.size() == DEPTH) begin
      exp_ovr = 1'b1;
      if (exp_cnt < CNT_MAX) exp_cnt++;
    end else exp_q.push_back(w);
  endtask

  task automatic check_status(input string nm);
    int sz;
    sz = exp_q.size();
    chk({nm, " level"}, rxq_level_o, sz);
    chk({nm, " full"}, rxq_full_o, (sz == DEPTH));
    chk({nm, " not_empty"}, rxq_not_empty_o, (sz != 0));
    chk({nm, " hwm"}, rxq_hwm_o, (hwm_i != 0 && sz >= int'(hwm_i)));
    chk({nm, " ovr"}, rxq_ovr_o, exp_ovr);
    chk({nm, " ovr_cnt"}, rxq_ovr_cnt_o, exp_cnt);
  endtask

  task automatic send_async(input int nbits, input int data, input bit stop,
                            input int bits_cfg = -1, input bit flip = 1'b0);
    int f, p;
    f = frame_bits(nbits, data, stop);
    p = int'(baud_i) + 1;
    bits_i = (bits_cfg < 0) ? 5'(nbits) : 5'(bits_cfg);
    for (int i = 0; i < nbits; i++) begin
      rxd_i = f[i];
      if (flip && i == nbits/2) sync_i = 1'b1;
      tick(p);
    end
    rxd_i = 1'b1;
    tick(p);
    if (flip) sync_i = 1'b0;
    tick(2);
    if (bits_i >= 2) model_push(model_word(nbits, data, stop));
  endtask

  task automatic rxc_cycle();
    rxc_i = 1'b0; tick(25);
    rxc_i = 1'b1; tick(25);
  endtask

  task automatic send_sync(input int nbits, input int data, input bit stop);
    int f;
    f = frame_bits(nbits, data, stop);
    bits_i = 5'(nbits);
    rxd_i = 1'b1;
    rxc_cycle(); rxc_cycle();
    for (int i = 0; i < nbits; i++) begin
      rxd_i = f[i];
      rxc_cycle();
    end
    rxd_i = 1'b1;
    rxc_cycle();
    rxc_i = 1'b0;
    tick(2);
    model_push(model_word(nbits, data, stop));
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rxq_oe_i = ($urandom_range(0, 3) != 0);
      rxq_pop_i = 1'b1;
      tick();
    end
    rxq_pop_i = 1'b0;
    rxq_oe_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int pops = 0;
    while (rxq_not_empty_o && pops < 2*DEPTH) begin
      rxq_oe_i = ($urandom_range(0, 3) != 0);
      rxq_pop_i = 1'b1;
      tick();
      pops++;
    end
    rxq_pop_i = 1'b0;
    chk({nm, " drained"}, rxq_not_empty_o, 0);
    chk({nm, " words left in model"}, exp_q.size(), 0);
    if (pops > 0) begin
      rxq_oe_i = 1'b1;
      tick();
      chk({nm, " head hold"}, {rxq_ferr_o, rxq_dat_o}, last_w);
    end
    rxq_oe_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic clear_err();
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    exp_ovr = 1'b0; exp_cnt = 0;
  endtask

  initial begin
    #1800us;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, f;
    reset_i = 1; bits_i = 5'd10; baud_i = 32'd49; sync_i = 0; rxd_i = 1; rxc_i = 0;
    rxq_pop_i = 0; rxq_oe_i = 0; rxq_flush_i = 0; hwm_i = '0; err_clr_i = 0;
    tick(3);
    reset_i = 0;
    tick();

    // Reset state and pops on an empty queue
    pop_n(4);
    rxq_oe_i = 0; tick();
    chk("t1 dat oe0", rxq_dat_o, 0);
    check_status("t1");
    rxq_oe_i = 1; tick();
    chk("t1 dat oe1", {rxq_ferr_o, rxq_dat_o}, 0);
    rxq_oe_i = 0;

    // Four 8N1 frames fill the queue
    send_async(10, 8'h85, 1); send_async(10, 8'hA1, 1);
    send_async(10, 8'h85, 1); send_async(10, 8'hA1, 1);
    check_status("t2");
    rxq_oe_i = 1; tick();
    chk("t2 head literal", {rxq_ferr_o, rxq_dat_o}, {1'b0, 12'b1_10000101_0_11});
    rxq_oe_i = 0;
    drain("t2");

    // Overrun on the fifth frame
    for (int i = 0; i < 5; i++) send_async(10, int'($urandom_range(0, 255)), 1);
    check_status("t3 ovr");
    drain("t3");
    clear_err(); tick();
    check_status("t3 clr");

    // Framing error and false start
    send_async(10, 8'h41, 0);
    rxq_oe_i = 1; tick();
    chk("t4 ferr literal", {rxq_ferr_o, rxq_dat_o}, {1'b1, 12'b0_01000001_0_11});
    rxq_oe_i = 0;
    rxd_i = 0; tick(15); rxd_i = 1; tick(150);
    check_status("t4 glitch");
    drain("t4");

    // Synchronous mode with high-water mark
    hwm_i = 3'd2; sync_i = 1; tick(3);
    send_sync(10, 8'h85, 1);
    check_status("t5 first");
    rxq_oe_i = 1; tick();
    chk("t5 head literal", {rxq_ferr_o, rxq_dat_o}, {1'b0, 12'b1_10000101_0_11});
    rxq_oe_i = 0;
    send_sync(10, int'($urandom_range(0, 255)), 1);
    check_status("t5 second");
    drain("t5");
    sync_i = 0; hwm_i = '0; tick(3);

    // Reset mid-frame, then overrun, partial pop and flush
    send_async(10, 8'h3C, 1);
    p = int'(baud_i) + 1;
    f = frame_bits(10, 8'h5A, 1);
    for (int i = 0; i < 4; i++) begin rxd_i = f[i]; tick(p); end
    reset_i = 1; rxd_i = 1; tick(2); reset_i = 0;
    exp_q.delete(); exp_ovr = 0; exp_cnt = 0;
    tick(12*p);
    check_status("t6 reset");
    rxq_oe_i = 1; tick();
    chk("t6 reset dat", {rxq_ferr_o, rxq_dat_o}, 0);
    rxq_oe_i = 0;
    for (int i = 0; i < 5; i++) send_async(10, int'($urandom_range(0, 255)), 1);
    check_status("t6 ovr");
    pop_n(1);
    check_status("t6 level3");
    rxq_flush_i = 1; tick(); rxq_flush_i = 0;
    exp_q.delete();
    check_status("t6 flush");
    send_async(10, int'($urandom_range(0, 255)), 1);
    check_status("t6 after flush");
    drain("t6");

    // Counter saturation at a fast bit rate
    baud_i = 32'd9;
    clear_err();
    for (int i = 0; i < 9; i++) send_async(10, int'($urandom_range(0, 255)), 1);
    check_status("sat");
    drain("sat");
    clear_err(); tick();

    // Random bursts: frame length, bit rate, stop bit, clamped/disabled bits_i, sync_i flips
    for (int b = 0; b < 6; b++) begin
      int nf;
      baud_i = 32'($urandom_range(9, 60));
      hwm_i = 3'($urandom_range(0, 4));
      nf = $urandom_range(1, 6);
      for (int k = 0; k < nf; k++) begin
        int kind, nb, d;
        bit st;
        kind = $urandom_range(0, 9);
        nb = $urandom_range(4, 12);
        d = int'($urandom);
        st = ($urandom_range(0, 4) != 0);
        if (kind == 0)      send_async(12, d, st, 20);
        else if (kind == 1) send_async(nb, d, st, 1);
        else if (kind == 2) send_async(nb, d, st, -1, 1'b1);
        else                send_async(nb, d, st);
      end
      check_status("rand burst");
      drain("rand");
      if ($urandom_range(0, 1) == 1) begin clear_err(); tick(); check_status("rand clr"); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
